adc_stream_arbiter: RTL and testbench
=====================================

ADC_STREAM_ARBITER -- requirements
Module: adc_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all tdata buses.
REQ-002 SHALL have input aclk, 1 bit, single clock for all logic.
REQ-003 SHALL have input areset, 1 bit; reset is synchronous to aclk and active-high.
REQ-004 SHALL have inputs s_axis_a_tdata (DATA_WIDTH) and s_axis_a_tvalid (1), plus output s_axis_a_tready (1): source A stream.
REQ-005 SHALL have inputs s_axis_b_tdata (DATA_WIDTH) and s_axis_b_tvalid (1), plus output s_axis_b_tready (1): source B stream.
REQ-006 SHALL have outputs m_axis_s2mm_tdata (DATA_WIDTH), m_axis_s2mm_tvalid (1), m_axis_s2mm_tlast (1) and m_axis_s2mm_tuser (1), plus input m_axis_s2mm_tready (1): merged stream; tuser is the source ID (0=A, 1=B).
REQ-007 SHALL have input config_reg, 32 bits: packet length in words; 0 means disabled.
REQ-008 SHALL have output packet_count, 32 bits: number of completed packets.
REQ-009 SHALL have output busy, 1 bit: high while a packet is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_A and GRANT_B.
REQ-011 In IDLE with config_reg!=0, SHALL grant a requesting source on the next cycle: a source requests when its tvalid is high; if both request, the one not granted last wins; after reset, A wins.
REQ-012 SHALL latch config_reg into an internal length register on the IDLE->GRANT transition; config_reg changes mid-packet SHALL NOT affect the current packet.
REQ-013 In GRANT_x, m_axis_s2mm_tdata/tvalid SHALL equal the granted source's tdata/tvalid combinationally, and the granted source's tready SHALL equal m_axis_s2mm_tready.
REQ-014 The non-granted source's tready SHALL be 0.
REQ-015 In IDLE, all treadys and m_axis_s2mm_tvalid SHALL be 0.
REQ-016 m_axis_s2mm_tuser SHALL equal the grant ID whenever tvalid is high.
REQ-017 SHALL count words with a 32-bit beat counter, incremented on each tvalid&&tready beat and cleared at packet start.
REQ-018 m_axis_s2mm_tlast SHALL be high exactly on the beat where beat counter == latched length-1.
REQ-019 On the tlast beat, SHALL increment packet_count (wrapping 2^32-1 -> 0) and return to IDLE on the next cycle.
REQ-020 A packet SHALL NOT be interrupted: source switching occurs only at packet boundaries, and the minimum gap between packets is one IDLE cycle.
REQ-021 When the granted source drops tvalid mid-packet, the grant SHALL be held and no beat counted; there SHALL be no timeout.
REQ-022 busy SHALL be high in GRANT_A/GRANT_B and low in IDLE.
REQ-023 With latched length 1, every beat SHALL carry tlast.
REQ-024 config_reg==0 SHALL be checked only in IDLE: no new grant is issued, and a packet in progress completes with its latched length.

Reset
REQ-025 While areset is high at a clock edge: state IDLE, beat counter 0, packet_count 0, latched length 0, last-grant = B (so A wins first).
REQ-026 During and after reset until the first grant: all tready, m_axis_s2mm_tvalid, tlast, tuser and busy SHALL be 0.
REQ-027 Reset asserted mid-packet SHALL abort the packet with no tlast emitted and leave packet_count at 0.

Verification
REQ-028 config_reg=4, only A valid, m_tready=1 -> 4 beats with tuser=0, tlast on beat 4, packet_count=1, one IDLE cycle, then the next packet starts.
REQ-029 config_reg=3, A and B continuously valid -> packets alternate A,B,A with tuser 0,1,0; each has 3 beats with tlast on beat 3; B's tready is 0 throughout A's packets.
REQ-030 config_reg=5, A valid, m_tready toggled 1/0 -> beats counted only on handshakes; tlast on the 5th handshake; tdata order matches the A source sequence exactly.
REQ-031 config_reg=8 set, then changed to 2 after 3 beats -> current packet ends after 8 beats; the next packet has 2 beats.
REQ-032 config_reg=0, both sources valid -> no tready and no tvalid for 20 cycles; busy=0; packet_count=0.
REQ-033 areset pulsed after 2 of 6 beats -> outputs 0 the next cycle, packet_count=0, first packet after release granted to A with beat counter restarting at 0.

Source files
------------

// File: rtl/adc_stream_arbiter.sv
// ---------------------------------------------------------------------------
// adc_stream_arbiter
//
// Merges two AXI-Stream sources (A and B) into one S2MM stream, one whole
// packet at a time. The packet length comes from config_reg, which is
// sampled when a grant is issued. While a grant is held, the granted
// source is wired straight through to the output. The non-granted source
// is stalled. When both sources request at the same time, the source that
// was not granted last wins. After reset, A wins first.
//
// Ports
//   aclk, areset          : clock, synchronous active-high reset
//   s_axis_a_*            : source A stream (tdata/tvalid in, tready out)
//   s_axis_b_*            : source B stream (tdata/tvalid in, tready out)
//   m_axis_s2mm_*         : merged stream (tdata/tvalid/tlast/tuser out,
//                           tready in); tuser = source id (0=A, 1=B)
//   config_reg            : packet length in words, 0 = no new grants
//   packet_count          : completed packets, wraps at 2^32
//   busy                  : high while a packet is granted
// ---------------------------------------------------------------------------
module adc_stream_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,

   input  logic [DATA_WIDTH-1:0] s_axis_a_tdata,
   input  logic                  s_axis_a_tvalid,
   output logic                  s_axis_a_tready,

   input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
   input  logic                  s_axis_b_tvalid,
   output logic                  s_axis_b_tready,

   output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
   output logic                  m_axis_s2mm_tvalid,
   output logic                  m_axis_s2mm_tlast,
   output logic                  m_axis_s2mm_tuser,
   input  logic                  m_axis_s2mm_tready,

   input  logic [31:0]           config_reg,
   output logic [31:0]           packet_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   state_t      state_reg,        state_next;
   logic        last_grant_b_reg, last_grant_b_next;
   logic [31:0] len_reg,          len_next;
   logic [31:0] beat_reg,         beat_next;
   logic [31:0] packet_count_reg, packet_count_next;

   // Internal helpers for the grant-phase datapath
   logic        last_beat;
   logic        beat_fire;

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg        <= IDLE;
         last_grant_b_reg <= 1'b1;   // pretend B was last so A wins first
         len_reg          <= '0;
         beat_reg         <= '0;
         packet_count_reg <= '0;
      end else begin
         state_reg        <= state_next;
         last_grant_b_reg <= last_grant_b_next;
         len_reg          <= len_next;
         beat_reg         <= beat_next;
         packet_count_reg <= packet_count_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and output logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next         = state_reg;
      last_grant_b_next  = last_grant_b_reg;
      len_next           = len_reg;
      beat_next          = beat_reg;
      packet_count_next  = packet_count_reg;

      s_axis_a_tready    = 1'b0;
      s_axis_b_tready    = 1'b0;
      m_axis_s2mm_tdata  = '0;
      m_axis_s2mm_tvalid = 1'b0;
      m_axis_s2mm_tlast  = 1'b0;
      m_axis_s2mm_tuser  = 1'b0;
      busy               = 1'b0;
      last_beat          = 1'b0;
      beat_fire          = 1'b0;

      case (state_reg)
         IDLE: begin
            // config_reg is only looked at here. A packet that is already
            // running always finishes with the length it latched.
            if (config_reg != 32'd0) begin
               if (s_axis_a_tvalid && (!s_axis_b_tvalid || last_grant_b_reg)) begin
                  state_next        = GRANT_A;
                  last_grant_b_next = 1'b0;
                  len_next          = config_reg;
                  beat_next         = '0;
               end else if (s_axis_b_tvalid) begin
                  state_next        = GRANT_B;
                  last_grant_b_next = 1'b1;
                  len_next          = config_reg;
                  beat_next         = '0;
               end
            end
         end

         GRANT_A: begin
            m_axis_s2mm_tdata  = s_axis_a_tdata;
            m_axis_s2mm_tvalid = s_axis_a_tvalid;
            m_axis_s2mm_tuser  = 1'b0;
            s_axis_a_tready    = m_axis_s2mm_tready;
         end

         GRANT_B: begin
            m_axis_s2mm_tdata  = s_axis_b_tdata;
            m_axis_s2mm_tvalid = s_axis_b_tvalid;
            m_axis_s2mm_tuser  = 1'b1;
            s_axis_b_tready    = m_axis_s2mm_tready;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (state_reg == GRANT_A || state_reg == GRANT_B) begin
         busy      = 1'b1;
         last_beat = (beat_reg == len_reg - 32'd1);
         beat_fire = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
         // tlast is only shown with a valid word. A stalled source never
         // presents a dangling tlast.
         m_axis_s2mm_tlast = m_axis_s2mm_tvalid && last_beat;

         // A dropped tvalid only stalls the packet. There is no timeout,
         // so the grant stays with the current source.
         if (beat_fire) begin
            if (last_beat) begin
               packet_count_next = packet_count_reg + 32'd1;
               beat_next         = '0;
               state_next        = IDLE;   // forces at least one idle cycle
            end else begin
               beat_next = beat_reg + 32'd1;
            end
         end
      end
   end

   assign packet_count = packet_count_reg;

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_stream_arbiter
//
// A packet-level reference model runs in the stimulus process. Each cycle it
// tracks the current owner, the position in the packet and the completed
// packet count. When it predicts a handshake, it pushes the expected word
// (data, source id, last flag) into a queue. A separate monitor runs on the
// falling edge. It pops the queue on every output handshake and also checks
// the ready, valid and busy levels against the model owner.
// ---------------------------------------------------------------------------
module tb_adc_stream_arbiter;

   localparam int DW = 32;

   logic          aclk;
   logic          areset;
   logic [DW-1:0] s_axis_a_tdata, s_axis_b_tdata;
   logic          s_axis_a_tvalid, s_axis_b_tvalid;
   logic          s_axis_a_tready, s_axis_b_tready;
   logic [DW-1:0] m_axis_s2mm_tdata;
   logic          m_axis_s2mm_tvalid, m_axis_s2mm_tlast, m_axis_s2mm_tuser;
   logic          m_axis_s2mm_tready;
   logic [31:0]   config_reg;
   logic [31:0]   packet_count;
   logic          busy;

   adc_stream_arbiter #(.DATA_WIDTH(DW)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .s_axis_a_tdata     (s_axis_a_tdata),
      .s_axis_a_tvalid    (s_axis_a_tvalid),
      .s_axis_a_tready    (s_axis_a_tready),
      .s_axis_b_tdata     (s_axis_b_tdata),
      .s_axis_b_tvalid    (s_axis_b_tvalid),
      .s_axis_b_tready    (s_axis_b_tready),
      .m_axis_s2mm_tdata  (m_axis_s2mm_tdata),
      .m_axis_s2mm_tvalid (m_axis_s2mm_tvalid),
      .m_axis_s2mm_tlast  (m_axis_s2mm_tlast),
      .m_axis_s2mm_tuser  (m_axis_s2mm_tuser),
      .m_axis_s2mm_tready (m_axis_s2mm_tready),
      .config_reg         (config_reg),
      .packet_count       (packet_count),
      .busy               (busy)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Expected output word
   typedef struct {
      logic [DW-1:0] data;
      logic          user;
      logic          last;
   } exp_t;

   exp_t q[$];

   int          checks = 0;
   int          errors = 0;

   // Reference model state (owner: 0 = none, 1 = A, 2 = B)
   int          owner  = 0;
   bit          last_b = 1'b1;
   int unsigned len    = 0;
   int unsigned idx    = 0;
   int unsigned cnt    = 0;
   int unsigned a_head = 0;
   int unsigned b_head = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance the model over the clock edge that has just passed. It uses
   // the inputs that were applied during the cycle before that edge.
   task automatic model_step();
      bit hs;
      if (areset) begin
         owner  = 0;
         last_b = 1'b1;
         cnt    = 0;
         idx    = 0;
      end else if (owner == 0) begin
         if (config_reg != 0 && (s_axis_a_tvalid || s_axis_b_tvalid)) begin
            if (s_axis_a_tvalid && s_axis_b_tvalid)
               owner = last_b ? 1 : 2;
            else
               owner = s_axis_a_tvalid ? 1 : 2;
            last_b = (owner == 2);
            len    = config_reg;
            idx    = 0;
         end
      end else begin
         hs = ((owner == 1) ? s_axis_a_tvalid : s_axis_b_tvalid) && m_axis_s2mm_tready;
         if (hs) begin
            if (owner == 1) a_head++; else b_head++;
            if (idx == len - 1) begin
               cnt++;
               owner = 0;
               idx   = 0;
            end else begin
               idx++;
            end
         end
      end
   endtask

   // Run one clock: update the model, apply new inputs, and queue the
   // handshake expected in the coming cycle.
   task automatic step(input bit va, input bit vb, input bit mr,
                       input logic [31:0] cfg, input bit rst);
      exp_t e;
      @(posedge aclk);
      #1;
      model_step();
      s_axis_a_tvalid    = va;
      s_axis_b_tvalid    = vb;
      m_axis_s2mm_tready = mr;
      config_reg         = cfg;
      areset             = rst;
      s_axis_a_tdata     = 32'hA000_0000 + a_head;
      s_axis_b_tdata     = 32'hB000_0000 + b_head;
      if (owner != 0 && ((owner == 1) ? va : vb) && mr) begin
         e.data = (owner == 1) ? s_axis_a_tdata : s_axis_b_tdata;
         e.user = (owner == 2);
         e.last = (idx == len - 1);
         q.push_back(e);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      @(posedge aclk);
      forever begin
         @(negedge aclk);
         chk("busy", busy, owner != 0);
         chk("a_tready", s_axis_a_tready, owner == 1 && m_axis_s2mm_tready);
         chk("b_tready", s_axis_b_tready, owner == 2 && m_axis_s2mm_tready);
         chk("m_tvalid", m_axis_s2mm_tvalid,
             (owner == 1) ? s_axis_a_tvalid : (owner == 2) ? s_axis_b_tvalid : 1'b0);
         chk("packet_count", packet_count, cnt);
         if (owner == 0) chk("idle_tlast", m_axis_s2mm_tlast, 1'b0);
         if (m_axis_s2mm_tvalid) chk("tuser", m_axis_s2mm_tuser, owner == 2);
         if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk("beat_data", m_axis_s2mm_tdata, e.data);
               chk("beat_user", m_axis_s2mm_tuser, e.user);
               chk("beat_last", m_axis_s2mm_tlast, e.last);
               $display("beat src=%0d data=%h last=%0b", e.user, e.data, e.last);
            end
         end
      end
   end

   // Stimulus
   initial begin
      int guard;
      logic [31:0] cfg;
      bit rst;
      areset = 1'b1;
      s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; m_axis_s2mm_tready = 0;
      config_reg = 0;
      s_axis_a_tdata = '0; s_axis_b_tdata = '0;

      // Reset with traffic offered: nothing may be granted
      for (int i = 0; i < 3; i++) step(1, 1, 1, 4, 1);

      // Length 4, only A, sink always ready
      for (int i = 0; i < 20; i++) step(1, 0, 1, 4, 0);
      // Length 3, both sources always valid: grants must alternate
      for (int i = 0; i < 30; i++) step(1, 1, 1, 3, 0);
      // Length 5, A valid, sink ready toggling
      for (int i = 0; i < 30; i++) step(1, 0, i[0], 5, 0);

      // Let the current packet finish, then use length 8 and change it to 2
      // after three beats
      guard = 0;
      while (owner != 0 && guard < 40) begin step(1, 0, 1, 0, 0); guard++; end
      guard = 0;
      while (!(owner == 1 && idx == 3) && guard < 40) begin step(1, 0, 1, 8, 0); guard++; end
      chk("len8_reached", owner == 1 && idx == 3, 1'b1);
      for (int i = 0; i < 20; i++) step(1, 0, 1, 2, 0);

      // Length 0 with both valid: the running packet drains, then nothing
      for (int i = 0; i < 25; i++) step(1, 1, 1, 0, 0);

      // Reset in the middle of a length-6 packet
      guard = 0;
      while (!(owner != 0 && idx == 2) && guard < 40) begin step(1, 1, 1, 6, 0); guard++; end
      chk("len6_reached", owner != 0 && idx == 2, 1'b1);
      step(1, 1, 1, 6, 1);
      for (int i = 0; i < 15; i++) step(1, 1, 1, 6, 0);

      // Random traffic
      cfg = 3;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 5))
               0: cfg = 0;
               1: cfg = 1;
               2: cfg = 2;
               3: cfg = 3;
               4: cfg = 5;
               default: cfg = 7;
            endcase
         end
         rst = ($urandom_range(0, 299) == 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, cfg, rst);
      end

      // Drain the packet that is still open
      guard = 0;
      while (owner != 0 && guard < 50) begin step(1, 1, 1, 0, 0); guard++; end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("drained", owner, 0);
      chk("queue_empty", q.size(), 0);
      chk("final_count", packet_count, cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
